// File: rtl/master_if_pkg.sv
// Shared types and helpers for the buffered crossbar master interface.
package master_if_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  // Queued entry is packed as {cmd, addr, wdata}.
  function automatic int unsigned entry_w(int unsigned addr_w, int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/master_req_fifo.sv
// Synchronous request FIFO: registered pointers/count, head entry visible combinationally.
module master_req_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PtrW + 1)'(Depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/master_if_buffered.sv
// Buffered crossbar master interface: queues requests, issues them one at a time, returns
// in-order registered responses. Optional request timeout under MASTER_IF_TIMEOUT_EN.
module master_if_buffered
  import master_if_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_from_master,
  input  logic [ADDR_W-1:0] addr_from_master,
  input  logic [DATA_W-1:0] wdata_from_master,
  input  logic              cmd_from_master,
  output logic              ready_to_master,
  output logic              ack_to_master,
  output logic [DATA_W-1:0] rdata_to_master,
  output logic              err_to_master,
  output logic              req_to_crossbar,
  output logic [ADDR_W-1:0] addr_to_crossbar,
  output logic [DATA_W-1:0] wdata_to_crossbar,
  output logic              cmd_to_crossbar,
  input  logic              ack_from_crossbar,
  input  logic [DATA_W-1:0] rdata_from_crossbar,
  input  logic              connect_approved_from_crossbar
);

  localparam int unsigned EntryW = entry_w(ADDR_W, DATA_W);

  state_e            state_q, state_d;
  logic              push, pop, full, empty, granted, done, timed_out;
  logic [EntryW-1:0] head;
  logic              head_cmd;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  assign ready_to_master = ~full;
  assign push            = req_from_master & ~full;
  assign {head_cmd, head_addr, head_wdata} = head;

  master_req_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({cmd_from_master, addr_from_master, wdata_from_master}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign granted = (state_q == StReq) & connect_approved_from_crossbar;
  assign done    = granted & ack_from_crossbar;
  assign pop     = done | timed_out;

`ifdef MASTER_IF_TIMEOUT_EN
  logic [15:0] wait_q;

  // A real ack in the timeout cycle takes priority over the abort.
  assign timed_out = (state_q == StReq) & ~done & (wait_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || state_q != StReq || pop) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_q + 16'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timed_out      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty) state_d = StReq;
      StReq:   if (pop) state_d = StResp;
      StResp:  state_d = empty ? StIdle : StReq;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    err_d   = timed_out;
    if (done && head_cmd == CMD_READ) rdata_d = rdata_from_crossbar;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign ack_to_master     = (state_q == StResp);
  assign rdata_to_master   = rdata_q;
  assign err_to_master     = err_q;
  assign req_to_crossbar   = (state_q == StReq);
  assign addr_to_crossbar  = granted ? head_addr : '0;
  assign wdata_to_crossbar = granted ? head_wdata : '0;
  assign cmd_to_crossbar   = granted ? head_cmd : CMD_READ;

endmodule

// File: tb/tb_master_if_buffered.sv
// Self-checking bench for master_if_buffered: directed vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_master_if_buffered;
  import master_if_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 8;

  logic        clk = 1'b0;
  logic        rst, req, cmd_m, appr, ack;
  logic [31:0] addr_m, wdata_m, xrd;
  logic        ready, ack_m, err_m, req_x, cmd_x;
  logic [31:0] rdata_m, addr_x, wdata_x;

  always #5 clk = ~clk;

  master_if_buffered #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .DEPTH   (DEPTH),
    .TIMEOUT (TMO)
  ) dut (
    .clk                            (clk),
    .rst                            (rst),
    .req_from_master                (req),
    .addr_from_master               (addr_m),
    .wdata_from_master              (wdata_m),
    .cmd_from_master                (cmd_m),
    .ready_to_master                (ready),
    .ack_to_master                  (ack_m),
    .rdata_to_master                (rdata_m),
    .err_to_master                  (err_m),
    .req_to_crossbar                (req_x),
    .addr_to_crossbar               (addr_x),
    .wdata_to_crossbar              (wdata_x),
    .cmd_to_crossbar                (cmd_x),
    .ack_from_crossbar              (ack),
    .rdata_from_crossbar            (xrd),
    .connect_approved_from_crossbar (appr)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: queue of accepted requests. A head request is presented from
  // max(push+2, previous response+1); a completion at cycle t responds at t+1.
  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          push_cyc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] done_addr[$];
  int          last_resp = -100;
  int          resp_due = -1;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        pushed, completed;
  int          n_ackm = 0, n_errm = 0, n_reqx = 0;

  task automatic cycle();
    int   start;
    logic in_req, appr_ok;
    @(negedge clk);
    if (!rst) begin
      in_req = 1'b0;
      start  = 0;
      if (mq.size() != 0) begin
        start  = (mq[0].push_cyc + 2 > last_resp + 1) ? mq[0].push_cyc + 2 : last_resp + 1;
        in_req = (cyc >= start);
      end
      appr_ok = in_req && appr;
      chk("ready_to_master", ready, mq.size() != DEPTH);
      chk("req_to_crossbar", req_x, in_req);
      chk("addr_to_crossbar", addr_x, appr_ok ? mq[0].addr : 32'h0);
      chk("wdata_to_crossbar", wdata_x, appr_ok ? mq[0].wdata : 32'h0);
      chk("cmd_to_crossbar", cmd_x, appr_ok ? mq[0].cmd : 1'b0);
      chk("ack_to_master", ack_m, resp_due == cyc);
      chk("rdata_to_master", rdata_m, (resp_due == cyc) ? resp_data : 32'h0);
      chk("err_to_master", err_m, (resp_due == cyc) ? resp_err : 1'b0);
      if (ack_m === 1'b1) n_ackm++;
      if (err_m === 1'b1) n_errm++;
      if (req_x === 1'b1) n_reqx++;
      pushed    = req && (mq.size() != DEPTH);
      completed = 1'b0;
      if (appr_ok && ack) begin
        completed = 1'b1;
        resp_data = (mq[0].cmd == CMD_READ) ? xrd : 32'h0;
        resp_err  = 1'b0;
      end
`ifdef MASTER_IF_TIMEOUT_EN
      else if (in_req && (cyc - start) == int'(TMO) - 1) begin
        completed = 1'b1;
        resp_data = 32'h0;
        resp_err  = 1'b1;
      end
`endif
      if (completed) begin
        done_addr.push_back(mq[0].addr);
        void'(mq.pop_front());
        resp_due  = cyc + 1;
        last_resp = cyc + 1;
      end
      if (pushed) mq.push_back('{cmd_m, addr_m, wdata_m, cyc});
    end else begin
      mq.delete();
      resp_due  = -1;
      last_resp = -100;
      pushed    = 1'b0;
      completed = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    req = 0; cmd_m = 0; addr_m = 0; wdata_m = 0; appr = 0; ack = 0; xrd = 0;
  endtask

  typedef struct {
    logic        req;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        appr;
    logic        ack;
    logic [31:0] xrd;
    logic        e_ready;
    logic        e_reqx;
    logic [31:0] e_addrx;
    logic [31:0] e_wdx;
    logic        e_cmdx;
    logic        e_ackm;
    logic [31:0] e_rdm;
  } vec_t;

  vec_t vt[13];

  initial begin
    // Immediate-grant read, then a write held off by approval (gating and ack-without-grant).
    vt[0]  = '{1, 0, 32'h10, 0,        1, 0, 0,            1, 0, 0,     0,        0, 0, 0};
    vt[1]  = '{0, 0, 0,      0,        1, 0, 0,            1, 0, 0,     0,        0, 0, 0};
    vt[2]  = '{0, 0, 0,      0,        1, 1, 32'hCAFEF00D, 1, 1, 32'h10, 0,       0, 0, 0};
    vt[3]  = '{0, 0, 0,      0,        1, 0, 0,            1, 0, 0,     0,        0, 1, 32'hCAFEF00D};
    vt[4]  = '{0, 0, 0,      0,        0, 0, 0,            1, 0, 0,     0,        0, 0, 0};
    vt[5]  = '{1, 1, 32'h20, 32'h55AA, 0, 0, 0,            1, 0, 0,     0,        0, 0, 0};
    vt[6]  = '{0, 0, 0,      0,        0, 0, 0,            1, 0, 0,     0,        0, 0, 0};
    vt[7]  = '{0, 0, 0,      0,        0, 0, 0,            1, 1, 0,     0,        0, 0, 0};
    vt[8]  = '{0, 0, 0,      0,        1, 0, 0,            1, 1, 32'h20, 32'h55AA, 1, 0, 0};
    vt[9]  = '{0, 0, 0,      0,        0, 1, 32'h1234,     1, 1, 0,     0,        0, 0, 0};
    vt[10] = '{0, 0, 0,      0,        1, 1, 32'hDEAD,     1, 1, 32'h20, 32'h55AA, 1, 0, 0};
    vt[11] = '{0, 0, 0,      0,        0, 0, 0,            1, 0, 0,     0,        0, 1, 0};
    vt[12] = '{0, 0, 0,      0,        0, 0, 0,            1, 0, 0,     0,        0, 0, 0};

    idle_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 0;
    #3;
    chk("reset_ready", ready, 1'b1);
    chk("reset_req_x", req_x, 1'b0);
    chk("reset_ack_m", ack_m, 1'b0);
    chk("reset_rdata", rdata_m, 32'h0);
    chk("reset_err", err_m, 1'b0);
    cycle();

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      req = vt[i].req; cmd_m = vt[i].cmd; addr_m = vt[i].addr; wdata_m = vt[i].wdata;
      appr = vt[i].appr; ack = vt[i].ack; xrd = vt[i].xrd;
      #3;
      chk($sformatf("vec%0d_ready", i), ready, vt[i].e_ready);
      chk($sformatf("vec%0d_req_x", i), req_x, vt[i].e_reqx);
      chk($sformatf("vec%0d_addr_x", i), addr_x, vt[i].e_addrx);
      chk($sformatf("vec%0d_wdata_x", i), wdata_x, vt[i].e_wdx);
      chk($sformatf("vec%0d_cmd_x", i), cmd_x, vt[i].e_cmdx);
      chk($sformatf("vec%0d_ack_m", i), ack_m, vt[i].e_ackm);
      chk($sformatf("vec%0d_rdata_m", i), rdata_m, vt[i].e_rdm);
      cycle();
    end

    // Full FIFO: four writes fill it, fifth is held until a slot frees.
    idle_inputs();
    done_addr.delete();
    req = 1; cmd_m = CMD_WRITE;
    for (int i = 0; i < 4; i++) begin
      addr_m = 32'h200 + 32'(4 * i); wdata_m = 32'(i + 1);
      cycle();
    end
    addr_m = 32'h210; wdata_m = 32'h5;
    #3;
    chk("full_ready_low", ready, 1'b0);
    begin
      int acks0, acc;
      acks0 = n_ackm;
      acc = 0;
      appr = 1; ack = 1;
      for (int i = 0; i < 20; i++) begin
        cycle();
        if (pushed && acc == 0) begin
          acc = 1;
          req = 0;
        end
      end
      chk("full_fifth_accepted", 32'(acc), 32'h1);
      chk("full_ack_count", 32'(n_ackm - acks0), 32'h5);
    end
    chk("full_done_count", 32'(done_addr.size()), 32'h5);
    for (int i = 0; i < 5 && i < done_addr.size(); i++) begin
      chk($sformatf("full_order%0d", i), done_addr[i], 32'h200 + 32'(4 * i));
    end

    // Push in the same cycle as a pop.
    idle_inputs();
    done_addr.delete();
    req = 1; addr_m = 32'h100; cycle();
    addr_m = 32'h104; cycle();
    req = 0; cycle();
    req = 1; addr_m = 32'h108; appr = 1; ack = 1; xrd = 32'h100;
    #3;
    chk("pp_ready", ready, 1'b1);
    chk("pp_head", addr_x, 32'h100);
    cycle();
    req = 0; ack = 0; xrd = 32'h0;
    #3;
    chk("pp_ack", ack_m, 1'b1);
    chk("pp_rdata", rdata_m, 32'h100);
    for (int i = 0; i < 10; i++) begin
      ack = 1; xrd = $urandom;
      cycle();
    end
    chk("pp_done_count", 32'(done_addr.size()), 32'h3);
    for (int i = 0; i < 3 && i < done_addr.size(); i++) begin
      chk($sformatf("pp_order%0d", i), done_addr[i], 32'h100 + 32'(4 * i));
    end

    // Reset while a request is in REQ with three queued.
    idle_inputs();
    req = 1; cmd_m = CMD_READ;
    for (int i = 0; i < 3; i++) begin
      addr_m = 32'h300 + 32'(4 * i);
      cycle();
    end
    req = 0;
    cycle();
    #3;
    chk("rst_pre_req_x", req_x, 1'b1);
    rst = 1;
    cycle();
    rst = 0;
    #3;
    chk("rst_ready", ready, 1'b1);
    chk("rst_req_x", req_x, 1'b0);
    chk("rst_addr_x", addr_x, 32'h0);
    chk("rst_ack_m", ack_m, 1'b0);
    chk("rst_rdata_m", rdata_m, 32'h0);
    chk("rst_err_m", err_m, 1'b0);
    begin
      int acks0;
      acks0 = n_ackm;
      appr = 1; ack = 1; xrd = 32'hBAD;
      for (int i = 0; i < 8; i++) cycle();
      chk("rst_no_ack", 32'(n_ackm - acks0), 32'h0);
    end

`ifdef MASTER_IF_TIMEOUT_EN
    // Granted but never acked: aborts after TMO cycles in REQ, then the next entry proceeds.
    idle_inputs();
    done_addr.delete();
    req = 1; addr_m = 32'h400; cycle();
    addr_m = 32'h404; cycle();
    req = 0; appr = 1;
    begin
      int acks0, errs0, reqs0, found;
      acks0 = n_ackm; errs0 = n_errm; reqs0 = n_reqx; found = 0;
      for (int i = 0; i < 30 && found == 0; i++) begin
        cycle();
        if (n_ackm != acks0) found = 1;
      end
      chk("tmo_ack_seen", 32'(found), 32'h1);
      chk("tmo_err_seen", 32'(n_errm - errs0), 32'h1);
      chk("tmo_req_cycles", 32'(n_reqx - reqs0), 32'(TMO));
      ack = 1; xrd = 32'h77;
      for (int i = 0; i < 5; i++) cycle();
      chk("tmo_next_done", 32'(done_addr.size()), 32'h2);
    end
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      req = 1'($urandom_range(0, 1)); cmd_m = 1'($urandom_range(0, 1));
      addr_m = $urandom; wdata_m = $urandom;
      appr = ($urandom_range(0, 3) != 0); ack = 1'($urandom_range(0, 1)); xrd = $urandom;
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/master_if_buffered.md
Name: master_if_buffered

Overview:
Parametrised, registered successor to the crossbar master interface. It queues master requests in a DEPTH-entry FIFO and presents them one at a time to the crossbar. Each request is held until connect approval and slave ack arrive. The block then returns an in-order, one-cycle registered response to the master. It sits between each master and its crossbar input port, so a master can issue back-to-back requests without stalling on arbitration.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read/write data width
DEPTH, 4, request FIFO entries; power of two, >= 2
TIMEOUT, 255, cycles in REQ before abort (used only with the optional feature)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_from_master  input  1  master request valid
addr_from_master  input  ADDR_W  request address
wdata_from_master  input  DATA_W  write data
cmd_from_master  input  1  1 = write, 0 = read
ready_to_master  output  1  FIFO can accept a request this cycle
ack_to_master  output  1  one-cycle response strobe
rdata_to_master  output  DATA_W  read data, valid with ack_to_master
err_to_master  output  1  response aborted by timeout, valid with ack_to_master
req_to_crossbar  output  1  head request valid
addr_to_crossbar  output  ADDR_W  head address, gated by approval
wdata_to_crossbar  output  DATA_W  head write data, gated by approval
cmd_to_crossbar  output  1  head command, gated by approval
ack_from_crossbar  input  1  slave completion
rdata_from_crossbar  input  DATA_W  slave read data
connect_approved_from_crossbar  input  1  arbiter grant for this master

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- On reset:
  - FIFO flushed: pointers and count cleared.
  - FSM returns to IDLE.
  - ack_to_master, err_to_master and req_to_crossbar = 0; rdata_to_master = 0.
  - Any in-flight crossbar transaction is abandoned.
- FIFO write and status:
  - push = req_from_master & ready_to_master; ready_to_master = (count != DEPTH).
  - A request while full is ignored; the master must hold it.
  - Entry = {cmd, addr, wdata}, written on the clock edge.
  - Pointers are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits.
  - Simultaneous push and pop leaves count unchanged. Push while full is impossible because ready is low.
- FSM states: IDLE, REQ, RESP.
  - IDLE: go to REQ when count != 0.
  - REQ:
    - req_to_crossbar = 1.
    - addr/wdata/cmd_to_crossbar = head fields ANDed with connect_approved_from_crossbar; all zero when not approved.
    - When connect_approved_from_crossbar & ack_from_crossbar: pop the head, go to RESP.
    - On that transition, register rdata_from_crossbar for a read, or 0 for a write.
    - ack_from_crossbar without approval is ignored.
  - RESP:
    - ack_to_master = 1 for exactly one cycle, with rdata_to_master valid.
    - Next state is REQ if the post-pop count != 0, else IDLE.
    - rdata_to_master returns to 0 after RESP.
- Latency:
  - Push at cycle N makes req_to_crossbar high at N+2.
  - Ack at cycle M gives ack_to_master at M+1.
  - Minimum push-to-ack_to_master latency is 3 cycles.
- Ordering: responses are strictly in push order. There is one outstanding crossbar transaction at a time.
- Approval dropping mid-REQ: outputs are re-gated to 0, the request is held, and there is no pop.

Optional Feature:
MASTER_IF_TIMEOUT_EN:
- Defined:
  - An 8..16-bit wait counter clears on entry to REQ and increments each REQ cycle without a valid ack.
  - On reaching TIMEOUT: pop the head and go to RESP with err_to_master = 1 and rdata_to_master = 0.
  - An ack in the same cycle as timeout wins: normal response, err = 0.
- Undefined: no counter; err_to_master is tied to 0; REQ waits indefinitely.

Decomposition:
- Package master_if_pkg:
  - CMD_READ/CMD_WRITE constants.
  - State enum {IDLE, REQ, RESP}.
  - Parametrised entry struct or width function for {cmd, addr, wdata}.
- Sub-module master_req_fifo: synchronous FIFO with push/pop, full/empty and head output. The FSM and gating stay in the top.

Test Plan:
- Read, immediate grant: push read addr 0x10 at cycle 0, approval held high, ack at cycle 2 with rdata 0xCAFEF00D -> ack_to_master at cycle 3 with rdata 0xCAFEF00D.
- Gating: REQ with approval low -> addr/wdata/cmd_to_crossbar = 0 and req_to_crossbar = 1. Raise approval -> head addr appears the same cycle.
- Full: DEPTH=4, push 5 writes with approval low -> ready_to_master = 0 after the 4th. Then grant/ack all -> 4 in-order acks with rdata 0. 5th push accepted once ready returns.
- Simultaneous push/pop: count stays at 2 across the cycle; addresses returned in order 0x100, 0x104, 0x108.
- Reset mid-REQ with 3 queued -> next cycle all outputs 0, ready = 1, no ack_to_master is ever produced for flushed entries.
- (MASTER_IF_TIMEOUT_EN, TIMEOUT=8) grant without ack -> after 8 REQ cycles ack_to_master = 1, err_to_master = 1, rdata 0. The next entry proceeds.
